regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-bank write port (bank built from dff_SR cells) among N_REQ writeback
//  requesters (e.g. ALU, load unit, CSR unit). Round-robin arbitration, valid/ready handshake per
//  requester, optional multi-cycle lock. Drives a registered write strobe/address/data to the bank.
// PARAMETERS
//  N_REQ     3   number of requesters (2..8)
//  AW        5   register address width
//  DW        32  register data width
//  ZERO_DROP 1   1: writes to address 0 are accepted but wr_en stays 0 (hard-wired zero register)
// PORTS
//  clock      in   1         rising-edge clock
//  reset      in   1         asynchronous, active-low reset
//  req_valid  in   N_REQ     requester i has a write pending
//  req_lock   in   N_REQ     requester i asks to keep ownership after this transfer
//  req_addr   in   N_REQ*AW  flattened; slice i = [i*AW +: AW]
//  req_data   in   N_REQ*DW  flattened; slice i = [i*DW +: DW]
//  req_ready  out  N_REQ     one-hot or zero; transfer i occurs when req_valid[i] & req_ready[i]
//  wr_stall   in   1         datapath holds bank; no transfer while 1
//  wr_en      out  1         registered write strobe to bank
//  wr_addr    out  AW        registered
//  wr_data    out  DW        registered
//  owner      out  N_REQ     one-hot current lock owner, 0 when unlocked
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, rr pointer=0, wr_en=0, wr_addr=0, wr_data=0, owner=0.
//  - req_ready is combinational from state/pointer/req_valid/wr_stall; at most one bit set.
//  - wr_stall=1: req_ready=0, state and pointer unchanged, wr_en=0 next cycle.
//  - FSM IDLE: grant = first valid requester at or after ptr (wrapping N_REQ-1 -> 0).
//    On transfer by g: ptr <= (g+1) mod N_REQ; if req_lock[g] -> LOCK, owner <= onehot(g).
//  - FSM LOCK: only owner may get ready; others see ready=0 regardless of valid.
//    Owner transfer with req_lock=0 -> IDLE, owner<=0, ptr<=(g+1) mod N_REQ.
//    Owner req_valid=0 and req_lock=0 for a cycle -> IDLE (release without transfer), ptr unchanged.
//  - Latency: transfer in cycle t -> wr_en/wr_addr/wr_data valid in cycle t+1 for exactly 1 cycle.
//    No transfer in t -> wr_en=0 in t+1; wr_addr/wr_data hold last value.
//  - ZERO_DROP=1 and addr==0: handshake completes normally, pointer advances, wr_en=0.
//  - No valid requester: req_ready=0, no state change.
//  - Reset mid-lock: lock dropped, pending write (wr_en) cancelled immediately.
//  - req_valid must stay high with stable addr/data until accepted; arbiter does not check this.
// CONFIGURATION
//  WR_ARB_STATS_EN defined: adds output grant_cnt (N_REQ*16, flattened) - per-requester
//    16-bit transfer counters, saturating at 16'hFFFF, incremented on each accepted transfer
//    (including dropped zero-register writes), cleared by reset.
//  Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package wr_arb_pkg: state enum {IDLE, LOCK}, STAT_W=16, helper function onehot(idx).
//  Sub-module rr_pick (combinational): inputs req vector + pointer, outputs one-hot grant and index;
//  instantiated once. Top holds FSM, pointer, output registers, optional counters.
// TESTING
//  1. Reset low mid-traffic -> all outputs 0 asynchronously; after release, first grant goes to req0.
//  2. req_valid=3'b111 held, no lock -> grants 0,1,2,0 on consecutive cycles; wr_en=1 each cycle
//     from cycle 2 with wr_addr matching the previous grantee's slice.
//  3. req1 valid+lock for 3 transfers, req0/req2 valid throughout -> only req1 ready for 3 cycles,
//     owner=3'b010; lock drops on 3rd transfer -> next grant req2.
//  4. wr_stall=1 for 2 cycles with all requesters valid -> req_ready=0, wr_en=0 next cycle;
//     stall release resumes at same pointer.
//  5. req0 writes addr 0 data 32'hDEAD_BEEF (ZERO_DROP=1) -> ready=1, wr_en stays 0, pointer -> 1.
//  6. WR_ARB_STATS_EN: 70000 transfers by req2 -> grant_cnt slice 2 = 16'hFFFF, others unchanged.

Source files
------------

// File: rtl/wr_arb_pkg.sv
// Shared types and helpers for the register-bank write-port arbiter.
package wr_arb_pkg;

  localparam int unsigned STAT_W  = 16;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  // One-hot vector with bit idx set, sized for the largest supported requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    v[idx[2:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick
  import wr_arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int unsigned j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter with optional ownership lock for the shared register-bank write port.
// Optional per-requester transfer counters are built when WR_ARB_STATS_EN is defined.
module regfile_wr_arbiter
  import wr_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned AW        = 5,
  parameter int unsigned DW        = 32,
  parameter bit          ZERO_DROP = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*AW-1:0]     req_addr,
  input  logic [N_REQ*DW-1:0]     req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    wr_stall,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [DW-1:0]           wr_data,
`ifdef WR_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0] grant_cnt,
`endif
  output logic [N_REQ-1:0]        owner
);

  localparam int unsigned PW = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, ptr_inc, gnt_idx;
  logic [N_REQ-1:0]  pick_req, gnt, owner_d;
  logic              gnt_any, xfer, own_valid, own_lock;
  logic [AW-1:0]     g_addr, wr_addr_d;
  logic [DW-1:0]     g_data, wr_data_d;
  logic              wr_en_d;

  // While locked only the owner competes, so the picker can only return the owner.
  assign pick_req = (state_q == LOCK) ? (req_valid & owner) : req_valid;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = wr_stall ? '0 : gnt;
  assign xfer      = gnt_any & ~wr_stall;
  assign g_addr    = req_addr[32'(gnt_idx) * AW +: AW];
  assign g_data    = req_data[32'(gnt_idx) * DW +: DW];
  assign ptr_inc   = (gnt_idx == PW'(N_REQ - 1)) ? '0 : PW'(gnt_idx + 1'b1);
  assign own_valid = |(req_valid & owner);
  assign own_lock  = |(req_lock & owner);

  // Next-state, pointer, ownership and write-port values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    if (xfer) begin
      ptr_d     = ptr_inc;
      wr_en_d   = !(ZERO_DROP && (g_addr == '0));
      wr_addr_d = g_addr;
      wr_data_d = g_data;
    end
    case (state_q)
      IDLE: begin
        if (xfer && req_lock[gnt_idx]) begin
          state_d = LOCK;
          owner_d = N_REQ'(onehot(32'(gnt_idx)));
        end
      end
      LOCK: begin
        if (xfer) begin
          if (!req_lock[gnt_idx]) begin
            state_d = IDLE;
            owner_d = '0;
          end
        end else if (!wr_stall && !own_valid && !own_lock) begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner   <= owner_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end

`ifdef WR_ARB_STATS_EN
  // Saturating accepted-transfer counters, dropped zero-register writes included.
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (req_valid[i] && req_ready[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign grant_cnt[i*STAT_W +: STAT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter against a behavioural arbitration model.
// Exercises the WR_ARB_STATS_EN counters when that macro is defined.
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_lock, req_ready, owner;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wr_stall, wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
`ifdef WR_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  int            m_ptr, m_own;
  bit            m_locked;
  logic          m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  int            m_cnt[N];
  logic [N-1:0]  exp_r;

  regfile_wr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ZERO_DROP(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef WR_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .owner     (owner)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_ptr = 0; m_own = 0; m_locked = 0;
    m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  function automatic logic [N-1:0] model_ready();
    if (wr_stall) return '0;
    if (m_locked) return req_valid[m_own] ? N'(1 << m_own) : '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return N'(1 << j);
    end
    return '0;
  endfunction

  function automatic logic [N-1:0] exp_owner();
    return m_locked ? N'(1 << m_own) : '0;
  endfunction

  function automatic void model_update(input logic [N-1:0] r);
    int g;
    logic [AW-1:0] a;
    g = -1;
    for (int i = 0; i < N; i++) if (r[i]) g = i;
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      m_wr_en   = (a != '0);
      m_wr_addr = a;
      m_wr_data = req_data[g*DW +: DW];
      m_ptr     = (g + 1) % N;
      m_locked  = req_lock[g];
      m_own     = g;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else begin
      m_wr_en = 1'b0;
      if (!wr_stall && m_locked && !req_valid[m_own] && !req_lock[m_own]) m_locked = 0;
    end
  endfunction

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic set_addrs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(i * 7 + 3);
      req_data[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_lock = '0; wr_stall = 1'b0;
    req_addr = '0; req_data = '0;
    #2 reset = 1'b0;
    model_reset();
    #1; n_chk++;
    if ({wr_en, wr_addr, wr_data, owner} !== '0) begin
      n_fail++; $display("FAIL reset_init: got en=%b addr=%h data=%h owner=%b, want all 0", wr_en, wr_addr, wr_data, owner);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    // traffic with a lock so there is state to lose
    set_addrs(); req_valid = 3'b111; req_lock = 3'b001;
    for (int i = 0; i < 3; i++) begin
      exp_r = model_ready(); model_update(exp_r);
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    model_reset();
    #1; n_chk++;
    if ({wr_en, wr_addr, wr_data, owner} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got en=%b addr=%h data=%h owner=%b, want all 0", wr_en, wr_addr, wr_data, owner);
    end
    req_lock = '0;
    @(negedge clock); reset = 1'b1;
    #1; n_chk++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 001", req_ready);
    end
    exp_r = model_ready(); model_update(exp_r);
    @(posedge clock); #1; n_chk++;
    if ({wr_en, wr_addr, wr_data, owner} !== {m_wr_en, m_wr_addr, m_wr_data, exp_owner()}) begin
      n_fail++; $display("FAIL reset_first_write: got en=%b addr=%h want en=%b addr=%h", wr_en, wr_addr, m_wr_en, m_wr_addr);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
    pulse_reset();
    set_addrs(); req_valid = 3'b111; req_lock = '0; wr_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; n_chk++;
      if (req_ready !== seq[i]) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, seq[i]);
      end
      exp_r = model_ready(); model_update(exp_r);
      @(posedge clock); #1; n_chk++;
      if ({wr_en, wr_addr, wr_data, owner} !== {m_wr_en, m_wr_addr, m_wr_data, exp_owner()}) begin
        n_fail++; $display("FAIL rr_write[%0d]: got en=%b addr=%h data=%h want en=%b addr=%h data=%h",
                           i, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
      end
    end
  endtask

  task automatic test_lock();
    pulse_reset();
    set_addrs(); req_valid = 3'b001; req_lock = '0; wr_stall = 1'b0;
    exp_r = model_ready(); model_update(exp_r);
    @(posedge clock); #1;
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      req_lock = (i < 2) ? 3'b010 : 3'b000;
      #1; exp_r = model_ready(); n_chk++;
      if (req_ready !== exp_r) begin
        n_fail++; $display("FAIL lock_ready[%0d]: got %b want %b", i, req_ready, exp_r);
      end
      model_update(exp_r);
      @(posedge clock); #1; n_chk++;
      if ({wr_en, wr_addr, wr_data, owner} !== {m_wr_en, m_wr_addr, m_wr_data, exp_owner()}) begin
        n_fail++; $display("FAIL lock_out[%0d]: got en=%b addr=%h owner=%b want en=%b addr=%h owner=%b",
                           i, wr_en, wr_addr, owner, m_wr_en, m_wr_addr, exp_owner());
      end
    end
  endtask

  task automatic test_stall();
    set_addrs(); req_valid = 3'b111; req_lock = '0;
    for (int i = 0; i < 4; i++) begin
      wr_stall = (i < 2);
      #1; exp_r = model_ready(); n_chk++;
      if (req_ready !== exp_r) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b want %b", i, req_ready, exp_r);
      end
      model_update(exp_r);
      @(posedge clock); #1; n_chk++;
      if ({wr_en, wr_addr, wr_data, owner} !== {m_wr_en, m_wr_addr, m_wr_data, exp_owner()}) begin
        n_fail++; $display("FAIL stall_out[%0d]: got en=%b addr=%h want en=%b addr=%h", i, wr_en, wr_addr, m_wr_en, m_wr_addr);
      end
    end
    wr_stall = 1'b0;
  endtask

  task automatic test_zero_drop();
    set_addrs(); req_valid = 3'b001; req_lock = '0; wr_stall = 1'b0;
    req_addr[0 +: AW] = '0; req_data[0 +: DW] = 32'hDEAD_BEEF;
    #1; n_chk++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL zero_ready: got %b want 001", req_ready);
    end
    exp_r = model_ready(); model_update(exp_r);
    @(posedge clock); #1; n_chk++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL zero_wr_en: got %b want 0", wr_en);
    end
    req_valid = 3'b111;
    #1; n_chk++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL zero_ptr_adv: got %b want 010", req_ready);
    end
    exp_r = model_ready(); model_update(exp_r);
    @(posedge clock); #1;
  endtask

  task automatic test_release();
    pulse_reset();
    set_addrs(); wr_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = (i == 0) ? 3'b001 : (i == 1) ? 3'b000 : 3'b110;
      req_lock  = (i == 0) ? 3'b001 : 3'b000;
      #1; exp_r = model_ready(); n_chk++;
      if (req_ready !== exp_r) begin
        n_fail++; $display("FAIL release_ready[%0d]: got %b want %b", i, req_ready, exp_r);
      end
      model_update(exp_r);
      @(posedge clock); #1; n_chk++;
      if ({wr_en, wr_addr, owner} !== {m_wr_en, m_wr_addr, exp_owner()}) begin
        n_fail++; $display("FAIL release_out[%0d]: got en=%b owner=%b want en=%b owner=%b", i, wr_en, owner, m_wr_en, exp_owner());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      req_lock  = N'($urandom) & N'($urandom);
      wr_stall  = ($urandom_range(3) == 0);
      for (int k = 0; k < N; k++) begin
        req_addr[k*AW +: AW] = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
        req_data[k*DW +: DW] = $urandom;
      end
      #1; exp_r = model_ready(); n_chk++;
      if (req_ready !== exp_r) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, exp_r);
      end
      model_update(exp_r);
      @(posedge clock); #1; n_chk++;
      if ({wr_en, wr_addr, wr_data, owner} !== {m_wr_en, m_wr_addr, m_wr_data, exp_owner()}) begin
        n_fail++; $display("FAIL rand_out[%0d]: got en=%b addr=%h data=%h owner=%b want en=%b addr=%h data=%h owner=%b",
                           i, wr_en, wr_addr, wr_data, owner, m_wr_en, m_wr_addr, m_wr_data, exp_owner());
      end
    end
`ifdef WR_ARB_STATS_EN
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (grant_cnt[k*16 +: 16] !== 16'(m_cnt[k])) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", k, grant_cnt[k*16 +: 16], m_cnt[k]);
      end
    end
`endif
  endtask

`ifdef WR_ARB_STATS_EN
  task automatic test_stats();
    pulse_reset();
    set_addrs(); req_valid = 3'b100; req_lock = '0; wr_stall = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      exp_r = model_ready(); model_update(exp_r);
      @(posedge clock); #1;
    end
    n_chk++;
    if (grant_cnt[2*16 +: 16] !== 16'hFFFF) begin
      n_fail++; $display("FAIL stats_sat: got %h want ffff", grant_cnt[2*16 +: 16]);
    end
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (grant_cnt[k*16 +: 16] !== 16'(m_cnt[k])) begin
        n_fail++; $display("FAIL stats_other[%0d]: got %0d want %0d", k, grant_cnt[k*16 +: 16], m_cnt[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_stall();
    test_zero_drop();
    test_release();
    test_random();
`ifdef WR_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
